// File: rtl/adc_channel_sequencer.sv
// ADC channel sequencer: scans the enabled channels of a snapshotted mask in
// ascending order. For each channel it issues a one-cycle conversion request,
// waits for the done strobe (or abandons the conversion after a timeout) and
// emits one timestamped sample. A scan can repeat after a programmable gap.
module adc_channel_sequencer #(
  parameter int NUM_CHANNELS    = 16,
  parameter int CHANNEL_WIDTH   = $clog2(NUM_CHANNELS),
  parameter int TIMESTAMP_WIDTH = 32,
  parameter int TIMEOUT_CYCLES  = 100000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       single_shot,
  input  logic [NUM_CHANNELS-1:0]    channel_mask,
  input  logic [15:0]                scan_interval,
  input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
  input  logic                       fifo_full,
  output logic                       adc_conversion_start,
  output logic [CHANNEL_WIDTH-1:0]   adc_channel,
  input  logic                       adc_conversion_done,
  input  logic [15:0]                adc_data,
  output logic                       sample_valid,
  output logic [CHANNEL_WIDTH-1:0]   sample_channel,
  output logic [15:0]                sample_data,
  output logic [TIMESTAMP_WIDTH-1:0] sample_timestamp,
  output logic                       busy,
  output logic                       scan_done,
  output logic                       timeout_err,
  output logic [15:0]                timeout_count,
  output logic [15:0]                scan_count
);

  // Pointer carries one extra bit so that "past the last channel" is representable
  // and ends the scan instead of wrapping back to channel 0.
  localparam int PW = CHANNEL_WIDTH + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    IDLE, SELECT, START, WAIT_DONE, EMIT, WAIT_INTERVAL
  } state_t;

  state_t state, state_next;

  logic [NUM_CHANNELS-1:0]    mask_snap;
  logic [PW-1:0]              ptr;
  logic [TW-1:0]              tcnt;
  logic [15:0]                icnt;
  logic [TIMESTAMP_WIDTH-1:0] ts_start;
  logic                       found;
  logic [CHANNEL_WIDTH-1:0]   pick;
  logic                       timeout_hit;
  logic                       interval_over;
  logic                       mask_nonzero;
  logic [PW-1:0]              ptr_after;

  assign timeout_hit   = (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign interval_over = (icnt >= scan_interval);
  assign mask_nonzero  = |channel_mask;
  assign ptr_after     = {1'b0, adc_channel} + PW'(1);

  // Lowest snapshotted channel at or above the scan pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (mask_snap[i] && (PW'(i) >= ptr)) begin
        found = 1'b1;
        pick  = CHANNEL_WIDTH'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a dropped enable stops the scan at the next SELECT.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:          if (enable && mask_nonzero) state_next = SELECT;
      SELECT: begin
        if (!enable)          state_next = IDLE;
        else if (found)       state_next = START;
        else if (single_shot) state_next = IDLE;
        else                  state_next = WAIT_INTERVAL;
      end
      START:         if (!fifo_full) state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (adc_conversion_done) state_next = EMIT;
        else if (timeout_hit)    state_next = SELECT;
      end
      EMIT:          state_next = SELECT;
      WAIT_INTERVAL: begin
        if (!enable)            state_next = IDLE;
        else if (interval_over) state_next = mask_nonzero ? SELECT : IDLE;
      end
      default:       state_next = IDLE;
    endcase
  end

  // Strobes decoded from state; done beats a simultaneous timeout.
  always_comb begin
    busy                 = (state != IDLE);
    adc_conversion_start = (state == START) && !fifo_full;
    sample_valid         = (state == EMIT);
    scan_done            = (state == SELECT) && enable && !found;
    timeout_err          = (state == WAIT_DONE) && !adc_conversion_done && timeout_hit;
  end

  // Scan pointer, mask snapshot, counters and latched sample fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_snap        <= '0;
      ptr              <= '0;
      tcnt             <= '0;
      icnt             <= '0;
      ts_start         <= '0;
      adc_channel      <= '0;
      sample_channel   <= '0;
      sample_data      <= '0;
      sample_timestamp <= '0;
      timeout_count    <= '0;
      scan_count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && mask_nonzero) begin
            mask_snap <= channel_mask;
            ptr       <= '0;
          end
        end
        SELECT: begin
          if (enable && found) begin
            adc_channel <= pick;
          end else if (enable) begin
            scan_count <= scan_count + 16'd1;
            icnt       <= '0;
          end
        end
        START: begin
          if (!fifo_full) begin
            ts_start <= timestamp;
            tcnt     <= '0;
          end
        end
        WAIT_DONE: begin
          if (adc_conversion_done) begin
            sample_data      <= adc_data;
            sample_channel   <= adc_channel;
            sample_timestamp <= ts_start;
          end else if (timeout_hit) begin
            ptr <= ptr_after;
            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        EMIT: ptr <= ptr_after;
        WAIT_INTERVAL: begin
          if (interval_over) begin
            if (enable && mask_nonzero) begin
              mask_snap <= channel_mask;
              ptr       <= '0;
            end
          end else begin
            icnt <= icnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/adc_channel_sequencer.md
ADC_CHANNEL_SEQUENCER -- requirements
Module: adc_channel_sequencer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 16: number of ADC channels scanned.
REQ-002 SHALL have parameter CHANNEL_WIDTH, default $clog2(NUM_CHANNELS): channel index width.
REQ-003 SHALL have parameter TIMESTAMP_WIDTH, default 32: timestamp width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000: cycles in WAIT_DONE before a conversion is abandoned.
REQ-005 SHALL have one clock and a synchronous, active-low reset, with ports as follows:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  run scanning.
- single_shot  in  1  when 1, stop after one scan.
- channel_mask  in  NUM_CHANNELS  per-channel scan enable.
- scan_interval  in  16  idle cycles between scans.
- timestamp  in  TIMESTAMP_WIDTH  free-running time base.
- fifo_full  in  1  downstream backpressure.
- adc_conversion_start  out  1  one-cycle conversion request.
- adc_channel  out  CHANNEL_WIDTH  channel being converted.
- adc_conversion_done  in  1  conversion complete strobe.
- adc_data  in  16  conversion result, valid with done.
- sample_valid  out  1  one-cycle sample strobe.
- sample_channel  out  CHANNEL_WIDTH  sample channel.
- sample_data  out  16  sample value.
- sample_timestamp  out  TIMESTAMP_WIDTH  timestamp captured at the start pulse.
- busy  out  1  state != IDLE.
- scan_done  out  1  one-cycle pulse at end of each scan.
- timeout_err  out  1  one-cycle pulse on an abandoned conversion.
- timeout_count  out  16  saturating timeout counter.
- scan_count  out  16  completed scans, wraps.

Function
REQ-006 SHALL implement the states IDLE, SELECT, START, WAIT_DONE, EMIT and WAIT_INTERVAL.
REQ-007 IDLE: when enable=1 and channel_mask!=0, SHALL snapshot channel_mask, set the scan pointer to 0 and go to SELECT next cycle.
REQ-008 SELECT: SHALL pick the lowest-index snapshot bit at or above the pointer and go to START. If none remains, SHALL pulse scan_done, increment scan_count, then:
- go to IDLE if single_shot=1 or enable=0;
- otherwise go to WAIT_INTERVAL.
REQ-009 START with fifo_full=1: SHALL hold in START with no pulse.
REQ-010 START with fifo_full=0: SHALL assert adc_conversion_start for exactly one cycle, drive adc_channel, latch timestamp, clear the timeout counter and go to WAIT_DONE.
REQ-011 adc_channel SHALL hold stable from START until the state leaves WAIT_DONE.
REQ-012 WAIT_DONE: on adc_conversion_done, SHALL latch adc_data and go to EMIT. sample_valid SHALL assert the cycle after done (latency 1).
REQ-013 WAIT_DONE: if the timeout counter reaches TIMEOUT_CYCLES-1 without done, SHALL:
- pulse timeout_err;
- increment timeout_count, saturating at 0xFFFF;
- emit no sample;
- set pointer = channel+1 and go to SELECT.
REQ-014 If done and the timeout terminal count occur in the same cycle, done SHALL win and no timeout SHALL be recorded.
REQ-015 EMIT: SHALL assert sample_valid for one cycle with sample_channel, sample_data and sample_timestamp, set pointer = channel+1, and go to SELECT.
REQ-016 Pointer wrap: a pointer past NUM_CHANNELS-1 SHALL end the scan; the pointer SHALL NOT wrap within a scan.
REQ-017 WAIT_INTERVAL: SHALL count scan_interval cycles, then re-snapshot the mask, reset the pointer and go to SELECT.
REQ-018 scan_interval=0 SHALL go directly from scan end to a new scan via a single WAIT_INTERVAL cycle.
REQ-019 WAIT_INTERVAL SHALL go to IDLE if enable=0 or the new mask is 0.
REQ-020 channel_mask changes mid-scan SHALL take effect only at the next snapshot.
REQ-021 enable dropping mid-scan: an in-flight conversion SHALL complete or time out and its sample SHALL be emitted. No further START SHALL be entered; the FSM SHALL go to IDLE without pulsing scan_done.
REQ-022 adc_conversion_done outside WAIT_DONE SHALL be ignored.
REQ-023 sample_* outputs SHALL hold their last values between strobes.

Reset
REQ-024 On rst_n=0 at a clock edge, SHALL go to IDLE regardless of state, including mid-conversion.
REQ-025 Reset SHALL clear all strobes, busy, adc_channel, sample_channel, sample_data, sample_timestamp, timeout_count, scan_count, the pointer and the mask snapshot to 0.

Verification
REQ-026 Mask 0x0005, interval 0, done 50 cycles after each start -> samples on ch0 then ch2, each one cycle after done; scan_done after ch2; scan_count increments per scan.
REQ-027 fifo_full=1 held for 20 cycles while in START -> no adc_conversion_start for those 20 cycles; pulse one cycle after fifo_full falls.
REQ-028 Mask 0x0020, never assert done, TIMEOUT_CYCLES=100000 -> timeout_err exactly 100000 cycles after start; no sample_valid; timeout_count=1.
REQ-029 single_shot=1, mask 0xFFFF -> exactly 16 samples, ch0..15 in order, then busy=0.
REQ-030 Mask changed 0x000F->0x00F0 during ch1 -> scan finishes ch2, ch3; next scan covers ch4..7.
REQ-031 rst_n=0 during WAIT_DONE -> next cycle busy=0 and all outputs 0; a done arriving afterward produces no sample.
